// File: rtl/adj_map_arbiter.sv
// adj_map_arbiter: shares one adjacency-map query/reply port between two requesters.
// Build option ADJ_MAP_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise port 0 wins ties.
module adj_map_arbiter #(
    parameter int MAX_NODES  = 1024,
    parameter int NODE_WIDTH = $clog2(MAX_NODES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rq0_query_valid,
    output logic                  rq0_query_ready,
    input  logic [NODE_WIDTH-1:0] rq0_query_data,
    output logic                  rq0_reply_valid,
    input  logic                  rq0_reply_ready,
    output logic [NODE_WIDTH-1:0] rq0_reply_data,
    output logic                  rq0_reply_last,
    output logic                  rq0_reply_no_edges_found,
    input  logic                  rq1_query_valid,
    output logic                  rq1_query_ready,
    input  logic [NODE_WIDTH-1:0] rq1_query_data,
    output logic                  rq1_reply_valid,
    input  logic                  rq1_reply_ready,
    output logic [NODE_WIDTH-1:0] rq1_reply_data,
    output logic                  rq1_reply_last,
    output logic                  rq1_reply_no_edges_found,
    output logic                  map_query_valid,
    input  logic                  map_query_ready,
    output logic [NODE_WIDTH-1:0] map_query_data,
    input  logic                  map_reply_valid,
    output logic                  map_reply_ready,
    input  logic [NODE_WIDTH-1:0] map_reply_data,
    input  logic                  map_reply_last,
    input  logic                  map_reply_no_edges_found,
    output logic                  grant_id,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, QUERY, REPLY} state_t;
    state_t r_state;
    logic   r_grant;
    logic   r_busy;
    logic   w_query;
    logic   w_reply;
    logic   w_win;
    logic   w_done;
    assign w_query = r_state == QUERY;
    assign w_reply = r_state == REPLY;
    assign w_done  = map_reply_valid && map_reply_ready && (map_reply_last || map_reply_no_edges_found);
`ifdef ADJ_MAP_ARB_ROUND_ROBIN_EN
    logic   r_ptr;
    assign w_win = (rq0_query_valid && rq1_query_valid) ? r_ptr : rq1_query_valid;
`else
    assign w_win = !rq0_query_valid;
`endif
    assign map_query_valid = w_query && (r_grant ? rq1_query_valid : rq0_query_valid);
    assign map_query_data  = w_query ? (r_grant ? rq1_query_data : rq0_query_data) : '0;
    assign rq0_query_ready = w_query && !r_grant && map_query_ready;
    assign rq1_query_ready = w_query && r_grant && map_query_ready;
    assign map_reply_ready = w_reply && (r_grant ? rq1_reply_ready : rq0_reply_ready);
    assign rq0_reply_valid = w_reply && !r_grant && map_reply_valid;
    assign rq1_reply_valid = w_reply && r_grant && map_reply_valid;
    assign rq0_reply_data           = map_reply_data;
    assign rq1_reply_data           = map_reply_data;
    assign rq0_reply_last           = map_reply_last;
    assign rq1_reply_last           = map_reply_last;
    assign rq0_reply_no_edges_found = map_reply_no_edges_found;
    assign rq1_reply_no_edges_found = map_reply_no_edges_found;
    assign grant_id = r_grant;
    assign busy     = r_busy;
    // Transaction FSM: arbitrate in IDLE, hold grant through query handshake and reply until the terminating beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= 1'b0;
            r_busy  <= 1'b0;
`ifdef ADJ_MAP_ARB_ROUND_ROBIN_EN
            r_ptr   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (rq0_query_valid || rq1_query_valid) begin
                    r_state <= QUERY;
                    r_grant <= w_win;
                    r_busy  <= 1'b1;
                end
                QUERY: if (map_query_valid && map_query_ready) r_state <= REPLY;
                REPLY: if (w_done) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
`ifdef ADJ_MAP_ARB_ROUND_ROBIN_EN
                    r_ptr   <= ~r_grant;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
